spi_arbiter: RTL and testbench
==============================

// Module: spi_arbiter
// PURPOSE
//  Shares the single spi_if command port (12-bit dout, 10-bit din, cmd/wr/rd/ack) between NREQ requesters,
//  e.g. the wishbone_if and an auto-poll/DMA engine. Sits between the requesters and spi_if in top_level.
//  Grants round-robin, holds the grant until spi_if acks, and keeps the grant across transfers while the
//  owner asserts lock (multi-word SPI frames).
// PARAMETERS
//  NREQ     2    number of requesters, 2..4
//  DW_TX    12   width of requester->SPI data (matches spi_if din)
//  DW_RX    10   width of SPI->requester data (matches spi_if dout)
//  TIMEOUT  1023 cycles in BUSY without spi_ack before abort (used only with SPI_ARB_TIMEOUT_EN)
// PORTS
//  clk       in   1           system clock
//  rst       in   1           asynchronous reset, active-high
//  req_wr    in   NREQ        per-requester write strobe, level, held until its ack
//  req_rd    in   NREQ        per-requester read strobe, level, held until its ack
//  req_cmd   in   NREQ        per-requester cmd flag (command vs data word)
//  req_lock  in   NREQ        keep grant after ack while high
//  req_dout  in   NREQ*DW_TX  packed per-requester TX data, requester i at [i*DW_TX +: DW_TX]
//  req_din   out  DW_RX       RX data, broadcast to all requesters (= spi_din)
//  req_ack   out  NREQ        one-cycle ack to granted requester
//  spi_dout  out  DW_TX       to spi_if din
//  spi_cmd   out  1           to spi_if cmd
//  spi_wr    out  1           to spi_if wr
//  spi_rd    out  1           to spi_if rd
//  spi_din   in   DW_RX       from spi_if dout
//  spi_ack   in   1           from spi_if ack, one-cycle pulse
//  grant     out  NREQ        one-hot registered owner, 0 when free
//  busy      out  1           high in BUSY and HOLD
//  timeout   out  1           one-cycle abort pulse; tied 0 without SPI_ARB_TIMEOUT_EN
// BEHAVIOUR
//  Reset: state IDLE, grant=0, rr pointer=0, busy=0, timeout=0. All spi_* outputs and req_ack are 0.
//  FSM states:
//   IDLE: if any (req_wr|req_rd), latch the winner into grant at the next edge and go to BUSY.
//         Winner is the first requester at or after the pointer. Pointer <= winner+1 mod NREQ.
//   BUSY: spi_wr/rd/cmd/dout = granted requester's signals (combinational mux gated by state).
//         On spi_ack: req_ack[g]=spi_ack in the same cycle (combinational).
//         Next state is HOLD if req_lock[g]=1 in that cycle; otherwise IDLE with grant<=0.
//   HOLD: spi_* strobes are 0 and grant is kept.
//         A new req_wr/rd from the owner goes to BUSY next cycle, with no rearbitration.
//         Owner lock low goes to IDLE and grant<=0. Other requesters wait.
//  Latency: request to spi_wr/rd is 1 cycle. Back-to-back unlocked transfers have 1 idle cycle between them.
//  wr and rd both high from the owner: wr forwarded, rd forced to 0.
//  The owner drops its strobe before ack: the transfer is not cancelled.
//   - spi_wr/rd follow the owner's (now 0) strobe.
//   - The FSM stays in BUSY until spi_ack.
//  spi_ack outside BUSY is ignored and no req_ack is issued.
//  Reset asserted mid-transfer clears immediately and asynchronously. spi_if is reset by the same rst.
// CONFIGURATION
//  SPI_ARB_TIMEOUT_EN defined:
//   - A counter runs in BUSY and clears on entry.
//   - When it reaches TIMEOUT: pulse timeout, pulse req_ack[g] with req_din=0, go to IDLE, grant<=0 (lock ignored).
//  Not defined: no counter; BUSY waits for spi_ack indefinitely; timeout=0.
// STRUCTURE
//  spi_arb_defs.vh holds:
//   - state encodings: ST_IDLE=2'd0, ST_BUSY=2'd1, ST_HOLD=2'd2
//   - the DW_TX/DW_RX defaults
//   - the counter width $clog2(TIMEOUT+1)
//  Sub-module rr_arbiter (NREQ, combinational):
//   - inputs: request vector and pointer
//   - outputs: one-hot winner and encoded index
//  The FSM, mux and timer live in spi_arbiter.
// TESTING
//  1. req_wr=01, req_dout[0]=12'hA5C, ack 5 cycles later:
//     -> spi_wr=1 one cycle after request, spi_dout=A5C, req_ack=01 on the spi_ack cycle, grant=00 next cycle.
//  2. req_rd=11 simultaneous from reset, pointer=0 -> requester0 served first, then requester1.
//     Pointer ends at 0. spi_din=10'h155 is seen on req_din at each ack.
//  3. Requester1 with lock=1 issues 3 writes while requester0 requests continuously:
//     -> grant stays 10 through all 3 acks. Requester0 is granted only after lock drops.
//  4. Owner sets wr=rd=1 -> spi_wr=1, spi_rd=0.
//     Owner drops wr before ack -> still exactly one req_ack on spi_ack.
//  5. rst pulsed while BUSY -> grant=0, busy=0, spi_wr=0 asynchronously. No req_ack for the aborted transfer.
//  6. SPI_ARB_TIMEOUT_EN, TIMEOUT=16, spi_ack never arrives:
//     -> timeout and req_ack pulse 16 cycles after BUSY entry, then IDLE.
//     Without the macro: still BUSY after 100 cycles.

Source files
------------

// File: rtl/spi_arbiter_pkg.sv
// Shared types and defaults for the SPI command-port arbiter.
// State encodings, data-width defaults and the timeout counter width helper.
package spi_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int DW_TX_DEF = 12;
  localparam int DW_RX_DEF = 10;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/spi_arbiter_rr_arbiter.sv
// Round-robin pick: first requester at or after the pointer wins.
// Purely combinational, one-hot winner plus its encoded index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        gnt[(int'(ptr) + k) % NREQ] = 1'b1;
        idx   = IW'((int'(ptr) + k) % NREQ);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one spi_if command port among NREQ requesters: round-robin grant, held until ack, kept while lock.
// Optional BUSY watchdog under `SPI_ARB_TIMEOUT_EN; request-to-strobe latency is one cycle.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DW_TX   = DW_TX_DEF,
  parameter int DW_RX   = DW_RX_DEF,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [NREQ-1:0]       req_rd,
  input  logic [NREQ-1:0]       req_cmd,
  input  logic [NREQ-1:0]       req_lock,
  input  logic [NREQ*DW_TX-1:0] req_dout,
  output logic [DW_RX-1:0]      req_din,
  output logic [NREQ-1:0]       req_ack,
  output logic [DW_TX-1:0]      spi_dout,
  output logic                  spi_cmd,
  output logic                  spi_wr,
  output logic                  spi_rd,
  input  logic [DW_RX-1:0]      spi_din,
  input  logic                  spi_ack,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  timeout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] req_any;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            tmo;

  assign req_any = req_wr | req_rd;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req (req_any),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = cnt_width(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;

  // Counts cycles spent in BUSY; any other state leaves it at zero for the next entry.
  always_comb cnt_d = (state_q == ST_BUSY) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tmo = (state_q == ST_BUSY) && (cnt_q == CW'(TIMEOUT)) && !spi_ack;
`else
  // Never true: the watchdog is compiled out in this build.
  assign tmo = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_any) begin
          state_d = ST_BUSY;
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
          ptr_d   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      ST_BUSY: begin
        if (spi_ack) begin
          if (req_lock[gidx_q]) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else if (tmo) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      ST_HOLD: begin
        if (!req_lock[gidx_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (req_any[gidx_q]) begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Owner's strobes pass straight through while BUSY, so a dropped strobe is forwarded as 0.
  always_comb begin
    spi_wr   = 1'b0;
    spi_rd   = 1'b0;
    spi_cmd  = 1'b0;
    spi_dout = '0;
    req_ack  = '0;
    req_din  = spi_din;
    if (state_q == ST_BUSY) begin
      spi_wr           = req_wr[gidx_q];
      spi_rd           = req_rd[gidx_q] & ~req_wr[gidx_q];
      spi_cmd          = req_cmd[gidx_q];
      spi_dout         = req_dout[gidx_q*DW_TX +: DW_TX];
      req_ack[gidx_q]  = spi_ack | tmo;
    end
    if (tmo) req_din = '0;
  end

  assign grant   = grant_q;
  assign busy    = (state_q != ST_IDLE);
  assign timeout = tmo;

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed scenarios plus random traffic against an owner/transfer model.
// Watchdog expectations follow `SPI_ARB_TIMEOUT_EN, with the DUT built for TIMEOUT=16.
module tb_spi_arbiter;

  localparam int N   = 2;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_wr, req_rd, req_cmd, req_lock;
  logic [23:0] req_dout;
  logic [9:0]  req_din, spi_din;
  logic [1:0]  req_ack, grant;
  logic [11:0] spi_dout;
  logic        spi_cmd, spi_wr, spi_rd, spi_ack, busy, timeout;

  int n_err = 0;
  int n_checks = 0;

  // Model: who owns the port, whether a transfer is outstanding, next-preferred requester.
  int         m_owner, m_ptr, m_cnt;
  bit         m_active;
  logic [1:0] m_ack;

  spi_arbiter #(.NREQ(N), .DW_TX(12), .DW_RX(10), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_wr(req_wr), .req_rd(req_rd), .req_cmd(req_cmd), .req_lock(req_lock),
    .req_dout(req_dout), .req_din(req_din), .req_ack(req_ack),
    .spi_dout(spi_dout), .spi_cmd(spi_cmd), .spi_wr(spi_wr), .spi_rd(spi_rd),
    .spi_din(spi_din), .spi_ack(spi_ack),
    .grant(grant), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_active = 1'b0;
    m_ptr    = 0;
    m_cnt    = 0;
    m_ack    = '0;
  endtask

  function automatic bit model_tmo();
`ifdef SPI_ARB_TIMEOUT_EN
    return m_active && (m_cnt == TMO) && !spi_ack;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    bit tmo;
    int w;
    tmo = model_tmo();
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        w = (m_ptr + k) % N;
        if (req_wr[w] || req_rd[w]) begin
          m_owner  = w;
          m_active = 1'b1;
          m_cnt    = 0;
          m_ptr    = (w + 1) % N;
          break;
        end
      end
    end else if (m_active) begin
      if (spi_ack) begin
        m_active = 1'b0;
        if (!req_lock[m_owner]) m_owner = -1;
      end else if (tmo) begin
        m_active = 1'b0;
        m_owner  = -1;
      end else begin
        m_cnt++;
      end
    end else begin
      if (!req_lock[m_owner]) m_owner = -1;
      else if (req_wr[m_owner] || req_rd[m_owner]) begin
        m_active = 1'b1;
        m_cnt    = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin : expect_blk
    logic [1:0]  e_ack, e_grant;
    logic [11:0] e_dout;
    logic [9:0]  e_din;
    logic        e_wr, e_rd, e_cmd, e_tmo;
    if (rst) model_reset();
    e_tmo   = model_tmo();
    e_grant = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
    e_ack = '0; e_wr = 0; e_rd = 0; e_cmd = 0; e_dout = '0;
    if (m_active) begin
      e_wr   = req_wr[m_owner];
      e_rd   = req_rd[m_owner] && !req_wr[m_owner];
      e_cmd  = req_cmd[m_owner];
      e_dout = req_dout[m_owner*12 +: 12];
      if (spi_ack || e_tmo) e_ack[m_owner] = 1'b1;
    end
    e_din = e_tmo ? 10'd0 : spi_din;
    m_ack = e_ack;
    check_val("grant", grant, e_grant);
    check_val("busy", busy, m_owner >= 0);
    check_val("spi_strobes", {spi_wr, spi_rd, spi_cmd}, {e_wr, e_rd, e_cmd});
    check_val("spi_dout", spi_dout, e_dout);
    check_val("req_ack", req_ack, e_ack);
    check_val("req_din", req_din, e_din);
    check_val("timeout", timeout, e_tmo);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] pend;
    int r;
    rst = 1'b1;
    req_wr = '0; req_rd = '0; req_cmd = '0; req_lock = '0; req_dout = '0;
    spi_din = '0; spi_ack = 1'b0;
    tick(); #3;
    check_val("rst_grant", grant, 2'b00);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_spi", {spi_wr, spi_rd, spi_cmd, req_ack}, 5'd0);
    tick(); tick(); rst = 1'b0;

    // Single write, ack five cycles after the request.
    tick(); req_wr = 2'b01; req_dout[11:0] = 12'hA5C; req_cmd = 2'b01;
    #3 check_val("t1_wr_c0", spi_wr, 1'b0);
    tick(); #3;
    check_val("t1_wr_c1", spi_wr, 1'b1);
    check_val("t1_dout", spi_dout, 12'hA5C);
    repeat (3) tick();
    tick(); spi_ack = 1'b1;
    #3 check_val("t1_ack", req_ack, 2'b01);
    tick(); spi_ack = 1'b0; req_wr = '0; req_cmd = '0;
    #3 check_val("t1_free", grant, 2'b00);

    // Simultaneous reads from reset: requester 0 then 1, one idle cycle between.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; req_rd = 2'b11; spi_din = 10'h155;
    tick(); spi_ack = 1'b1;
    #3 check_val("t2_g0", grant, 2'b01);
    check_val("t2_ack0", req_ack, 2'b01);
    check_val("t2_din0", req_din, 10'h155);
    tick(); spi_ack = 1'b0; req_rd = 2'b10;
    #3 check_val("t2_gap", grant, 2'b00);
    tick(); spi_ack = 1'b1;
    #3 check_val("t2_g1", grant, 2'b10);
    check_val("t2_ack1", req_ack, 2'b10);
    check_val("t2_din1", req_din, 10'h155);
    tick(); spi_ack = 1'b0; req_rd = 2'b11;
    tick(); #3 check_val("t2_ptr0", grant, 2'b01);
    tick(); spi_ack = 1'b1;
    tick(); spi_ack = 1'b0; req_rd = '0;

    // Locked owner keeps the port for three writes while requester 0 waits.
    tick(); req_lock = 2'b10; req_wr = 2'b11; req_dout = {12'h111, 12'h222};
    tick(); #3 check_val("t3_first", grant, 2'b10);
    for (int j = 0; j < 3; j++) begin
      tick(); spi_ack = 1'b1;
      #3 check_val("t3_ack", req_ack, 2'b10);
      tick(); spi_ack = 1'b0; req_wr[1] = 1'b0;
      #3 check_val("t3_hold", grant, 2'b10);
      if (j < 2) begin
        tick(); req_wr[1] = 1'b1;
        tick(); #3 check_val("t3_again", {grant, spi_wr}, 3'b101);
      end
    end
    tick(); req_lock = '0;
    #3 check_val("t3_last_hold", grant, 2'b10);
    tick(); #3 check_val("t3_idle", grant, 2'b00);
    tick(); #3 check_val("t3_r0", grant, 2'b01);
    tick(); spi_ack = 1'b1;
    tick(); spi_ack = 1'b0; req_wr = '0;

    // wr and rd together, then strobes dropped before the ack.
    tick(); req_wr = 2'b01; req_rd = 2'b01;
    tick(); #3 check_val("t4_wr_only", {spi_wr, spi_rd}, 2'b10);
    tick(); req_wr = '0; req_rd = '0;
    #3 check_val("t4_dropped", {busy, spi_wr, spi_rd}, 3'b100);
    tick(); spi_ack = 1'b1;
    #3 check_val("t4_ack", req_ack, 2'b01);
    tick(); spi_ack = 1'b0;
    #3 check_val("t4_one_ack", {req_ack, grant}, 4'b0000);

    // Asynchronous reset in the middle of a transfer.
    tick(); req_wr = 2'b10;
    tick(); #3 check_val("t5_busy", busy, 1'b1);
    tick(); #1 rst = 1'b1;
    #1 check_val("t5_async", {grant, busy, spi_wr}, 4'b0000);
    tick(); rst = 1'b0; req_wr = '0; spi_ack = 1'b1;
    #3 check_val("t5_noack", req_ack, 2'b00);
    tick(); spi_ack = 1'b0;

    // No ack ever arrives.
    tick(); req_wr = 2'b01; spi_din = 10'h155;
    tick();
`ifdef SPI_ARB_TIMEOUT_EN
    for (int i = 1; i <= TMO; i++) begin
      tick(); #2;
      if (i == TMO - 1) check_val("t6_early", timeout, 1'b0);
      if (i == TMO) check_val("t6_tmo", {timeout, req_ack, req_din}, {1'b1, 2'b01, 10'h000});
    end
    tick(); req_wr = '0;
    #3 check_val("t6_idle", {grant, busy}, 3'b000);
`else
    repeat (100) tick();
    #2 check_val("t6_still_busy", {busy, timeout}, 2'b10);
    tick(); spi_ack = 1'b1;
    tick(); spi_ack = 1'b0; req_wr = '0;
`endif
    tick(); tick();

    // Random traffic from two agents plus a randomly acking SPI side.
    pend = '0;
    repeat (3000) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) begin
          pend[i] = 1'b0; req_wr[i] = 1'b0; req_rd[i] = 1'b0;
        end else if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            r = $urandom_range(0, 2);
            pend[i]    = 1'b1;
            req_wr[i]  = (r != 1);
            req_rd[i]  = (r != 0);
            req_cmd[i] = $urandom_range(0, 1) == 1;
            req_dout[i*12 +: 12] = 12'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0; req_wr[i] = 1'b0; req_rd[i] = 1'b0;
        end
        req_lock[i] = ($urandom_range(0, 2) == 0);
      end
      spi_ack = ($urandom_range(0, 3) == 0);
      spi_din = 10'($urandom);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
